// File: rtl/rv_hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
// Stage entries carry a fixed-width rd field so one struct serves any RW <= RW_MAX.
package rv_hazard_pkg;

    localparam int RW_MAX = 8;

    typedef struct packed {
        logic              valid;
        logic [RW_MAX-1:0] rd;
        logic              wb_en;
        logic              is_load;
    } stage_entry_t;

    localparam int           FWD_RF = 0;
    localparam stage_entry_t BUBBLE = '0;

    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port forward selection: picks the youngest tracked stage writing rs
// and flags it when that stage holds a load whose data is not yet available.
module fwd_port_match
    import rv_hazard_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int RW         = 5,
    parameter int LOAD_READY = 2,
    parameter int SELW       = sel_width(DEPTH)
) (
    input  stage_entry_t      stages_i [DEPTH],
    input  logic [RW-1:0]     rs_i,
    input  logic              used_i,
    output logic [SELW-1:0]   sel_o,
    output logic              not_ready_o
);

    logic              hit;
    logic              hitLoad;
    int                hitIdx;
    logic [RW_MAX-1:0] rsExt;

    assign rsExt = RW_MAX'(rs_i);

    // Scan oldest to youngest so the youngest matching stage overwrites the result.
    always_comb begin
        hit     = 1'b0;
        hitLoad = 1'b0;
        hitIdx  = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used_i && stages_i[k].valid && stages_i[k].wb_en &&
                (stages_i[k].rd != '0) && (stages_i[k].rd == rsExt)) begin
                hit     = 1'b1;
                hitLoad = stages_i[k].is_load;
                hitIdx  = k + 1;
            end
        end
    end

    assign not_ready_o = hit & hitLoad & (hitIdx < LOAD_READY);
    assign sel_o       = (hit && !not_ready_o) ? SELW'(hitIdx) : SELW'(FWD_RF);

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard control for the in-order pipeline: tracks post-EX writers,
// selects forward sources per EX read port, and stalls on load-use and MC-unit hazards.
module fwd_hazard_scoreboard
    import rv_hazard_pkg::*;
#(
    parameter int NREAD      = 2,
    parameter int DEPTH      = 2,
    parameter int RW         = 5,
    parameter int LOAD_READY = 2,
    parameter int MC_LAT     = 4,
    parameter int SELW       = sel_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic [NREAD*RW-1:0]    ex_rs,
    input  logic [NREAD-1:0]       ex_rs_used,
    input  logic [RW-1:0]          ex_rd,
    input  logic                   ex_wb_en,
    input  logic                   ex_is_load,
    input  logic                   ex_is_mc,
    input  logic                   pipe_flush,
    output logic                   stall,
    output logic [NREAD*SELW-1:0]  fwd_sel,
    output logic                   mc_wb_valid,
    output logic [RW-1:0]          mc_wb_rd
);

    localparam int CNTW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    stage_entry_t    stage_q [DEPTH];
    stage_entry_t    stageIn_d;
    logic            mcBusy_q;
    logic [CNTW-1:0] mcCnt_q;
    logic [RW-1:0]   mcRd_q;

    logic [NREAD-1:0] notReady;
    logic             loadUse;
    logic             mcRaw;
    logic             mcWaw;
    logic             mcStall;
    logic             mcAccept;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        fwd_port_match #(
            .DEPTH      (DEPTH),
            .RW         (RW),
            .LOAD_READY (LOAD_READY),
            .SELW       (SELW)
        ) u_match (
            .stages_i    (stage_q),
            .rs_i        (ex_rs[p*RW +: RW]),
            .used_i      (ex_rs_used[p] & ex_valid),
            .sel_o       (fwd_sel[p*SELW +: SELW]),
            .not_ready_o (notReady[p])
        );
    end

    assign loadUse     = |notReady;
    assign mc_wb_valid = mcBusy_q & (mcCnt_q == '0);
    assign mc_wb_rd    = mcRd_q;

    // Hazards against the in-flight MC op stay live through its writeback cycle.
    always_comb begin
        mcRaw = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            if (ex_rs_used[p] && (ex_rs[p*RW +: RW] == mcRd_q) && (mcRd_q != '0)) begin
                mcRaw = 1'b1;
            end
        end
    end

    assign mcWaw    = ex_wb_en & (ex_rd == mcRd_q);
    assign mcStall  = mcBusy_q & ex_valid & (ex_is_mc | mcRaw | mcWaw);
    assign stall    = ex_valid & ~pipe_flush & (loadUse | mcStall);
    assign mcAccept = ex_valid & ex_is_mc & ~stall & ~pipe_flush;

    // MC ops write back through their own port, so they never occupy a tracked stage.
    always_comb begin
        stageIn_d = BUBBLE;
        if (!(stall || pipe_flush || !ex_valid || ex_is_mc)) begin
            stageIn_d.valid   = 1'b1;
            stageIn_d.rd      = RW_MAX'(ex_rd);
            stageIn_d.wb_en   = ex_wb_en;
            stageIn_d.is_load = ex_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= BUBBLE;
            end
        end else begin
            stage_q[0] <= stageIn_d;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcBusy_q <= 1'b0;
            mcCnt_q  <= '0;
            mcRd_q   <= '0;
        end else if (mcAccept) begin
            mcBusy_q <= 1'b1;
            mcCnt_q  <= CNTW'(MC_LAT - 1);
            mcRd_q   <= ex_rd;
        end else if (mcBusy_q) begin
            if (mcCnt_q == '0) begin
                mcBusy_q <= 1'b0;
            end else begin
                mcCnt_q <= mcCnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Scoreboard bench for fwd_hazard_scoreboard with default parameters
// (NREAD=2, DEPTH=2, LOAD_READY=2, MC_LAT=4).
module tb_fwd_hazard_scoreboard;

    localparam int NREAD = 2;
    localparam int RW    = 5;
    localparam int SELW  = 2;

    typedef struct {
        string      name;
        logic       stall;
        logic [3:0] sel;
        logic       mcv;
        logic [4:0] mcRd;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  ex_valid;
    logic [NREAD*RW-1:0]   ex_rs;
    logic [NREAD-1:0]      ex_rs_used;
    logic [RW-1:0]         ex_rd;
    logic                  ex_wb_en;
    logic                  ex_is_load;
    logic                  ex_is_mc;
    logic                  pipe_flush;
    logic                  stall;
    logic [NREAD*SELW-1:0] fwd_sel;
    logic                  mc_wb_valid;
    logic [RW-1:0]         mc_wb_rd;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    fwd_hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_rs       (ex_rs),
        .ex_rs_used  (ex_rs_used),
        .ex_rd       (ex_rd),
        .ex_wb_en    (ex_wb_en),
        .ex_is_load  (ex_is_load),
        .ex_is_mc    (ex_is_mc),
        .pipe_flush  (pipe_flush),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .mc_wb_valid (mc_wb_valid),
        .mc_wb_rd    (mc_wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One EX cycle: drive just after the rising edge and queue what the outputs must show.
    task automatic applyStimulus(
        input string name,
        input logic v, input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
        input logic [4:0] rd, input logic wb, input logic ld, input logic mc, input logic fl,
        input logic eStall, input logic [1:0] eSel0, input logic [1:0] eSel1,
        input logic eMcv, input logic [4:0] eMcRd);
        exp_t e;
        @(posedge clk);
        #1;
        ex_valid   = v;
        ex_rs      = {rs1, rs0};
        ex_rs_used = used;
        ex_rd      = rd;
        ex_wb_en   = wb;
        ex_is_load = ld;
        ex_is_mc   = mc;
        pipe_flush = fl;
        e.name  = name;
        e.stall = eStall;
        e.sel   = {eSel1, eSel0};
        e.mcv   = eMcv;
        e.mcRd  = eMcRd;
        expQ.push_back(e);
    endtask

    task automatic idle(input string name, input logic eMcv, input logic [4:0] eMcRd);
        applyStimulus(name, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, eMcv, eMcRd);
    endtask

    // Monitor: compares every cycle that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput({e.name, " stall"}, 8'(stall), 8'(e.stall));
                checkOutput({e.name, " fwd_sel"}, 8'(fwd_sel), 8'(e.sel));
                checkOutput({e.name, " mc_wb_valid"}, 8'(mc_wb_valid), 8'(e.mcv));
                if (e.mcv) begin
                    checkOutput({e.name, " mc_wb_rd"}, 8'(mc_wb_rd), 8'(e.mcRd));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        ex_valid   = 1'b0;
        ex_rs      = '0;
        ex_rs_used = '0;
        ex_rd      = '0;
        ex_wb_en   = 1'b0;
        ex_is_load = 1'b0;
        ex_is_mc   = 1'b0;
        pipe_flush = 1'b0;
        #3;
        checkOutput("reset stall", 8'(stall), 8'h0);
        checkOutput("reset fwd_sel", 8'(fwd_sel), 8'h0);
        checkOutput("reset mc_wb_valid", 8'(mc_wb_valid), 8'h0);
        #9;
        rst = 1'b0;

        // Distance-based forwarding with DEPTH=2.
        applyStimulus("fwd1 producer", 1, 1, 2, 2'b00, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("fwd1 consumer", 1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        idle("gap", 0, 0); idle("gap", 0, 0);
        applyStimulus("fwd2 producer", 1, 1, 2, 2'b00, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("fwd2 bubble", 0, 0);
        applyStimulus("fwd2 consumer", 1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0, 2, 0, 0, 0);
        idle("gap", 0, 0); idle("gap", 0, 0);
        applyStimulus("fwd0 producer", 1, 1, 2, 2'b00, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("fwd0 bubble", 0, 0); idle("fwd0 bubble", 0, 0);
        applyStimulus("fwd0 consumer", 1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("gap", 0, 0); idle("gap", 0, 0);

        // Load-use: one stall cycle, then forward from WB on both ports.
        applyStimulus("lw x7", 1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("load-use stall", 1, 7, 7, 2'b11, 8, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus("load-use fwd", 1, 7, 7, 2'b11, 8, 1, 0, 0, 0, 0, 2, 2, 0, 0);
        idle("gap", 0, 0); idle("gap", 0, 0);

        // Youngest writer wins; x0 never forwards.
        applyStimulus("x9 older", 1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("x9 younger", 1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("x9 youngest wins", 1, 9, 0, 2'b01, 20, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        idle("gap", 0, 0); idle("gap", 0, 0);
        applyStimulus("x0 older", 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("x0 younger", 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("x0 no fwd", 1, 0, 0, 2'b01, 20, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("gap", 0, 0); idle("gap", 0, 0);

        // MC RAW: four stall cycles, writeback on the fourth, release on the fifth.
        applyStimulus("div x10", 1, 1, 2, 2'b11, 10, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("mc raw wait", 1, 10, 0, 2'b11, 11, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus("mc raw wb", 1, 10, 0, 2'b11, 11, 1, 0, 0, 0, 1, 0, 0, 1, 10);
        applyStimulus("mc raw release", 1, 10, 0, 2'b11, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("gap", 0, 0); idle("gap", 0, 0);

        // Structural hazard: second MC op waits for the first writeback.
        applyStimulus("div x12", 1, 1, 2, 2'b11, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("mc struct wait", 1, 1, 2, 2'b11, 13, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus("mc struct wb", 1, 1, 2, 2'b11, 13, 1, 0, 1, 0, 1, 0, 0, 1, 12);
        applyStimulus("mc struct accept", 1, 1, 2, 2'b11, 13, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle("mc2 busy", 0, 0); idle("mc2 busy", 0, 0); idle("mc2 busy", 0, 0);
        idle("mc2 wb", 1, 13);
        idle("gap", 0, 0);

        // Flushed second MC op: no stall and no acceptance.
        applyStimulus("div x12 again", 1, 1, 2, 2'b11, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("mc flushed", 1, 1, 2, 2'b11, 13, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        idle("mc busy", 0, 0); idle("mc busy", 0, 0);
        idle("mc wb after flush", 1, 12);
        idle("no second wb", 0, 0); idle("no second wb", 0, 0);
        idle("no second wb", 0, 0); idle("no second wb", 0, 0);

        // Reset while the MC op is pending with cnt==2.
        applyStimulus("div x14", 1, 1, 2, 2'b11, 14, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("add x3 under mc", 1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("raw before reset", 1, 14, 3, 2'b11, 16, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async reset stall", 8'(stall), 8'h0);
        checkOutput("async reset fwd_sel", 8'(fwd_sel), 8'h0);
        checkOutput("async reset mc_wb_valid", 8'(mc_wb_valid), 8'h0);
        #10;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) idle("no wb after reset", 0, 0);

        // Not-ready load forward but the consumer is flushed.
        applyStimulus("lw x15", 1, 0, 0, 2'b00, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("flushed consumer", 1, 15, 0, 2'b01, 16, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle("gap", 0, 0);

        for (int i = 0; i < 50 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
